// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller:
// FSM state encoding and the default operand width.
package serial_sub_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_sub_ctrl_pkg

// File: rtl/full_subtractor.sv
// 1-bit full subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Borrow when a is 0 and b is 1, or when a==b and a borrow ripples in.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule : full_subtractor

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: computes a - b - borrow_in LSB first,
// one bit per cycle, through a single shared full-subtractor cell.
// Start/done handshake; one operation every WIDTH+2 cycles.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  state_t             state_reg;
  state_t             state_next;
  logic [WIDTH-1:0]   a_sh_reg;
  logic [WIDTH-1:0]   b_sh_reg;
  logic [WIDTH-1:0]   diff_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               borrow_reg;
  logic               msb_bin_reg;
  logic               borrow_out_reg;
  logic               overflow_reg;

  logic               cell_d;
  logic               cell_bout;
  logic               accept;
  logic               last_bit;
  logic               pre_msb_bit;

  // The one shared arithmetic cell, fed from the operand LSBs and the borrow flop.
  full_subtractor u_cell (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .bin  (borrow_reg),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Handshake decode and bit-position markers.
  always_comb begin
    accept      = (state_reg == IDLE) && start && !clear;
    last_bit    = (cnt_reg == CNT_W'(WIDTH - 1));
    pre_msb_bit = (cnt_reg == CNT_W'(WIDTH - 2));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic; clear overrides everything, including start.
  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start) state_next = RUN;
        RUN:     if (last_bit) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Serial datapath: operand/result shifters, bit counter, borrow chain, results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg       <= '0;
      b_sh_reg       <= '0;
      diff_reg       <= '0;
      cnt_reg        <= '0;
      borrow_reg     <= 1'b0;
      msb_bin_reg    <= 1'b0;
      borrow_out_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else if (clear && (state_reg == RUN)) begin
      // An aborted operation must not leave a partial result visible.
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else if (accept) begin
      a_sh_reg       <= a;
      b_sh_reg       <= b;
      borrow_reg     <= borrow_in;
      cnt_reg        <= '0;
      msb_bin_reg    <= 1'b0;
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else if (state_reg == RUN) begin
      // Result bits enter at the MSB so after WIDTH shifts bit 0 lands at index 0.
      diff_reg   <= {cell_d, diff_reg[WIDTH-1:1]};
      a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
      b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
      borrow_reg <= cell_bout;
      cnt_reg    <= cnt_reg + CNT_W'(1);
      // Borrow leaving bit WIDTH-2 is the borrow into the sign bit.
      if (pre_msb_bit) begin
        msb_bin_reg <= cell_bout;
      end
      if (last_bit) begin
        borrow_out_reg <= cell_bout;
        overflow_reg   <= msb_bin_reg ^ cell_bout;
      end
    end
  end

  // Status and result outputs.
  always_comb begin
    ready      = (state_reg == IDLE);
    busy       = (state_reg == RUN);
    done       = (state_reg == DONE);
    diff       = diff_reg;
    borrow_out = borrow_out_reg;
    overflow   = overflow_reg;
  end

endmodule : serial_sub_ctrl

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl (WIDTH=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             clear;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  int err_cnt = 0;
  int chk_cnt = 0;

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clear      (clear),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for done; returns the cycle index (cycle 1 = cycle after
  // the accept edge) and how many of the preceding cycles had busy=1.
  task automatic wait_done(input int cyc_in, output int cyc_out, output int busy_n);
    int cyc;
    cyc    = cyc_in;
    busy_n = 0;
    while (!done && cyc < 30) begin
      if (busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
    cyc_out = cyc;
  endtask

  // One full operation with hand-computed expected results.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tbin, input logic [7:0] ed, input logic ebo,
                        input logic eov);
    int cyc;
    int busy_n;
    @(negedge clk);
    a = ta; b = tb_v; borrow_in = tbin; start = 1'b1;
    @(negedge clk);
    // Scramble operands after accept; they must not matter.
    start = 1'b0; a = ~ta; b = ~tb_v; borrow_in = ~tbin;
    wait_done(1, cyc, busy_n);
    check({tag, ".done_cycle"}, cyc, 9);
    check({tag, ".busy_cycles"}, busy_n, 8);
    check({tag, ".diff"}, diff, ed);
    check({tag, ".borrow_out"}, borrow_out, ebo);
    check({tag, ".overflow"}, overflow, eov);
    @(negedge clk);
    check({tag, ".done_pulse_len"}, done, 0);
    check({tag, ".ready_after"}, ready, 1);
    check({tag, ".diff_held"}, diff, ed);
    $display("op %-10s a=%02h b=%02h bin=%0d -> diff=%02h bo=%0d ov=%0d done@%0d",
             tag, ta, tb_v, tbin, diff, borrow_out, overflow, cyc);
  endtask

  initial begin
    int cyc;
    int busy_n;
    int done_seen;

    rst_n = 1'b0; start = 1'b0; clear = 1'b0;
    a = '0; b = '0; borrow_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.ready", ready, 1);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.diff", diff, 0);
    check("rst.borrow_out", borrow_out, 0);
    check("rst.overflow", overflow, 0);
    $display("reset state checked");
    rst_n = 1'b1;
    @(negedge clk);

    // Main arithmetic vectors.
    run_op("basic",   8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    run_op("underflw", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("sovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("sovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("bin_zero", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    run_op("bin_wrap", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);

    // start pulses during RUN and DONE must be ignored.
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    check("ign.ready_run", ready, 0);
    @(negedge clk);
    start = 1'b0;
    wait_done(4, cyc, busy_n);
    check("ign.done_cycle", cyc, 9);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    check("ign.ready_done", ready, 0);
    check("ign.diff_first", diff, 8'h1E);
    @(negedge clk);
    start = 1'b0;
    check("ign.ready_idle", ready, 1);
    check("ign.diff_kept", diff, 8'h1E);
    @(negedge clk);
    check("ign.not_started", busy, 0);
    check("ign.diff_stable", diff, 8'h1E);
    $display("op ignore    second start dropped, diff=%02h", diff);

    // clear at RUN cycle 4: abort with no done pulse and zeroed results.
    @(negedge clk);
    a = 8'hFF; b = 8'h00; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("clr.busy_before", busy, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr.ready", ready, 1);
    check("clr.busy", busy, 0);
    check("clr.done", done, 0);
    check("clr.diff", diff, 0);
    check("clr.borrow_out", borrow_out, 0);
    check("clr.overflow", overflow, 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("clr.no_done", done_seen, 0);
    $display("op clear     aborted at RUN cycle 4, diff=%02h", diff);
    run_op("post_clr", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);

    // Asynchronous reset between edges in the middle of RUN.
    @(negedge clk);
    a = 8'hFF; b = 8'h00; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("arst.diff_partial", diff, 8'h80);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.ready", ready, 1);
    check("arst.busy", busy, 0);
    check("arst.done", done, 0);
    check("arst.diff", diff, 0);
    check("arst.borrow_out", borrow_out, 0);
    check("arst.overflow", overflow, 0);
    $display("op async_rst outputs at reset values, diff=%02h", diff);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_serial_sub_ctrl
